// File: rtl/hit_detector_core.sv
// Press-timed hit/miss judge: verdict pulse two edges after the go rise, counted hits.
// No backpressure; presses arriving before the lockout expires are dropped, never queued.
module hit_detector_core #(
    parameter int STREAM_W = 9,
    parameter int HIT_LO   = 20,
    parameter int HIT_HI   = 40,
    parameter int COOLDOWN = 16,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                go,
    input  logic [STREAM_W-1:0] stream,
    output logic                hit,
    output logic                miss,
    output logic                busy,
    output logic [CNT_W-1:0]    hit_count
);

    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CD_W-1:0]     CD_LOAD = CD_W'(COOLDOWN - 1);
    localparam logic [STREAM_W-1:0] WIN_LO  = STREAM_W'(HIT_LO);
    localparam logic [STREAM_W-1:0] WIN_HI  = STREAM_W'(HIT_HI);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                go_q;
    logic                rise;
    logic                in_window;
    logic [STREAM_W-1:0] sample;
    logic [STREAM_W-1:0] sample_nxt;
    logic [CD_W-1:0]     cd_cnt;
    logic [CD_W-1:0]     cd_nxt;
    logic                hit_nxt;
    logic                miss_nxt;
    logic [CNT_W-1:0]    count_nxt;

    // go_q resets high so a key held through reset cannot look like a fresh press.
    assign rise      = go & ~go_q;
    assign in_window = (sample >= WIN_LO) && (sample <= WIN_HI);

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = EVAL;
            EVAL:    state_nxt = PULSE;
            PULSE:   state_nxt = HOLD;
            HOLD:    if ((cd_cnt == '0) && !go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hit_nxt    = 1'b0;
        miss_nxt   = 1'b0;
        count_nxt  = hit_count;
        sample_nxt = sample;
        cd_nxt     = cd_cnt;
        case (state)
            IDLE: begin
                if (rise) sample_nxt = stream;
            end
            EVAL: begin
                if (in_window) begin
                    hit_nxt   = 1'b1;
                    count_nxt = hit_count + 1'b1;
                end else begin
                    miss_nxt  = 1'b1;
                end
            end
            PULSE: begin
                cd_nxt = CD_LOAD;
            end
            HOLD: begin
                if (cd_cnt != '0) cd_nxt = cd_cnt - 1'b1;
            end
            default: begin
                cd_nxt = '0;
            end
        endcase
    end

    // busy tracks the state register exactly, since both load from state_nxt.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            go_q      <= 1'b1;
            sample    <= '0;
            cd_cnt    <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            busy      <= 1'b0;
            hit_count <= '0;
        end else begin
            go_q      <= go;
            sample    <= sample_nxt;
            cd_cnt    <= cd_nxt;
            hit       <= hit_nxt;
            miss      <= miss_nxt;
            busy      <= (state_nxt != IDLE);
            hit_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_hit_detector_core.sv
// Bench for hit_detector_core: scoreboard of expected verdicts checked against each pulse.
module tb_hit_detector_core;

    localparam int STREAM_W = 9;
    localparam int CNT_W    = 8;
    localparam int COOLDOWN = 16;

    logic                clk     = 1'b0;
    logic                reset_b = 1'b0;
    logic                go      = 1'b0;
    logic [STREAM_W-1:0] stream  = '0;
    logic                hit;
    logic                miss;
    logic                busy;
    logic [CNT_W-1:0]    hit_count;

    int         n_checks    = 0;
    int         n_fail      = 0;
    int         pulse_seen  = 0;
    bit         exp_q[$];
    bit         mon_e;
    logic [7:0] model_count = 8'd0;

    hit_detector_core #(
        .STREAM_W(STREAM_W),
        .HIT_LO  (20),
        .HIT_HI  (40),
        .COOLDOWN(COOLDOWN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .go       (go),
        .stream   (stream),
        .hit      (hit),
        .miss     (miss),
        .busy     (busy),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    // Every pulse must match the oldest outstanding verdict; extra pulses are errors.
    always @(negedge clk) begin
        if (hit === 1'b1 || miss === 1'b1) begin
            pulse_seen++;
            n_checks++;
            if (hit && miss) begin
                n_fail++;
                $display("FAIL both_pulses: hit=%b miss=%b, required only one at %0t", hit, miss, $time);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: hit=%b miss=%b, required no pulse at %0t", hit, miss, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e) model_count++;
                n_checks++;
                if (hit !== mon_e) begin
                    n_fail++;
                    $display("FAIL verdict: hit=%b, required %b at %0t", hit, mon_e, $time);
                end
                n_checks++;
                if (hit_count !== model_count) begin
                    n_fail++;
                    $display("FAIL pulse_count: hit_count=%0d, required %0d at %0t", hit_count, model_count, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset_b = 1'b1;
        go = 1'b0;
        exp_q.delete();
        model_count = 8'd0;
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b0;
    endtask

    task automatic press(input logic [STREAM_W-1:0] v, input bit expect_pulse, input bit exp_hit);
        @(posedge clk);
        #1 stream = v;
        go = 1'b1;
        if (expect_pulse) exp_q.push_back(exp_hit);
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b, required 0 within 200 cycles", busy);
        end
    endtask

    task automatic test_reset();
        #1 reset_b = 1'b1;
        #1;
        n_checks++;
        if ({hit, miss, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: hit/miss/busy=%b, required 000", {hit, miss, busy});
        end
        n_checks++;
        if (hit_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: hit_count=%0d, required 0", hit_count);
        end
        @(posedge clk);
        #1 reset_b = 1'b0;
    endtask

    task automatic test_hit();
        logic [1:0] hm[3];
        int busy_cycles = 0;
        @(posedge clk);
        #1 stream = 9'd30;
        go = 1'b1;
        exp_q.push_back(1'b1);
        @(posedge clk);
        #1 go = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k < 3) hm[k] = {hit, miss};
            if (busy !== 1'b1) break;
            busy_cycles++;
        end
        n_checks++;
        if (hm[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL hit_eval_cycle: hit/miss=%b, required 00", hm[0]);
        end
        n_checks++;
        if (hm[1] !== 2'b10) begin
            n_fail++;
            $display("FAIL hit_pulse_cycle: hit/miss=%b, required 10", hm[1]);
        end
        n_checks++;
        if (hm[2] !== 2'b00) begin
            n_fail++;
            $display("FAIL hit_after_pulse: hit/miss=%b, required 00", hm[2]);
        end
        n_checks++;
        if (busy_cycles != COOLDOWN + 2) begin
            n_fail++;
            $display("FAIL busy_length: busy for %0d cycles, required %0d", busy_cycles, COOLDOWN + 2);
        end
        n_checks++;
        if (hit_count !== 8'd1) begin
            n_fail++;
            $display("FAIL hit_count_first: hit_count=%0d, required 1", hit_count);
        end
    endtask

    task automatic test_miss();
        logic [1:0] hm[3];
        @(posedge clk);
        #1 stream = 9'd100;
        go = 1'b1;
        exp_q.push_back(1'b0);
        @(posedge clk);
        #1 go = 1'b0;
        stream = 9'd30;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hm[k] = {hit, miss};
        end
        n_checks++;
        if (hm[1] !== 2'b01) begin
            n_fail++;
            $display("FAIL miss_pulse: hit/miss=%b, required 01", hm[1]);
        end
        n_checks++;
        if (hm[0] !== 2'b00 || hm[2] !== 2'b00) begin
            n_fail++;
            $display("FAIL miss_width: before=%b after=%b, required 00 and 00", hm[0], hm[2]);
        end
        n_checks++;
        if (hit_count !== 8'd1) begin
            n_fail++;
            $display("FAIL miss_count: hit_count=%0d, required 1", hit_count);
        end
        wait_idle();
    endtask

    task automatic test_boundaries();
        logic [STREAM_W-1:0] bvals[5] = '{9'd20, 9'd40, 9'd19, 9'd41, 9'd511};
        bit                  bexp[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int p0;
        for (int i = 0; i < 5; i++) begin
            p0 = pulse_seen;
            press(bvals[i], 1'b1, bexp[i]);
            wait_idle();
            n_checks++;
            if (pulse_seen != p0 + 1) begin
                n_fail++;
                $display("FAIL boundary_pulses: stream=%0d gave %0d pulses, required 1", bvals[i], pulse_seen - p0);
            end
        end
        n_checks++;
        if (hit_count !== 8'd3) begin
            n_fail++;
            $display("FAIL boundary_count: hit_count=%0d, required 3", hit_count);
        end
    endtask

    task automatic test_reset_midrun();
        int p0;
        int k = 0;
        press(9'd30, 1'b1, 1'b1);
        while (hit !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        #1 reset_b = 1'b1;
        exp_q.delete();
        model_count = 8'd0;
        #1;
        n_checks++;
        if ({hit, miss, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset_outputs: hit/miss/busy=%b, required 000", {hit, miss, busy});
        end
        n_checks++;
        if (hit_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_count: hit_count=%0d, required 0", hit_count);
        end
        p0 = pulse_seen;
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (pulse_seen != p0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_pending: pulses=%0d busy=%b, required 0 and 0", pulse_seen - p0, busy);
        end
    endtask

    task automatic test_lockout();
        int p0;
        int k = 0;
        p0 = pulse_seen;
        @(posedge clk);
        #1 stream = 9'd30;
        go = 1'b1;
        exp_q.push_back(1'b1);
        repeat (50) @(posedge clk);
        #1 go = 1'b0;
        wait_idle();
        n_checks++;
        if (pulse_seen != p0 + 1) begin
            n_fail++;
            $display("FAIL held_go_pulses: got %0d pulses, required 1", pulse_seen - p0);
        end

        do_reset();
        p0 = pulse_seen;
        press(9'd30, 1'b1, 1'b1);
        while (hit !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        press(9'd30, 1'b0, 1'b0);
        wait_idle();
        n_checks++;
        if (pulse_seen != p0 + 1) begin
            n_fail++;
            $display("FAIL cooldown_press: got %0d pulses, required 1", pulse_seen - p0);
        end
        press(9'd30, 1'b1, 1'b1);
        wait_idle();
        n_checks++;
        if (hit_count !== 8'd2) begin
            n_fail++;
            $display("FAIL lockout_count: hit_count=%0d, required 2", hit_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) begin
            press(9'd25, 1'b1, 1'b1);
            wait_idle();
        end
        n_checks++;
        if (hit_count !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_top: hit_count=%0d, required 255", hit_count);
        end
        press(9'd35, 1'b1, 1'b1);
        wait_idle();
        n_checks++;
        if (hit_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: hit_count=%0d, required 0", hit_count);
        end
    endtask

    task automatic test_go_held_through_reset();
        int p0;
        @(posedge clk);
        #1 stream = 9'd30;
        go = 1'b1;
        reset_b = 1'b1;
        exp_q.delete();
        model_count = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b0;
        p0 = pulse_seen;
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (pulse_seen != p0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_through_reset: pulses=%0d busy=%b, required 0 and 0", pulse_seen - p0, busy);
        end
        go = 1'b0;
        press(9'd30, 1'b1, 1'b1);
        wait_idle();
        n_checks++;
        if (pulse_seen != p0 + 1 || hit_count !== 8'd1) begin
            n_fail++;
            $display("FAIL press_after_release: pulses=%0d hit_count=%0d, required 1 and 1", pulse_seen - p0, hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_boundaries();
        test_reset_midrun();
        test_lockout();
        test_wrap();
        test_go_held_through_reset();
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_verdicts: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
